// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-sequencer bundle: pipeline status toward the sequencer, stall/flush/hold controls back.
// The master side is the pipeline datapath, the slave side is pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_UsesRt;
    logic       EX_MemRead;
    logic [4:0] EX_WriteReg;
    logic       MEM_BranchTaken;
    logic       MEM_MemAccess;
    logic       Mem_Ready;
    logic       PCWre;
    logic       IF_ID_Write;
    logic       Stage_Hold;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       EX_MEM_Flush;
    logic       Trap;
    logic [1:0] State;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_WriteReg,
               MEM_BranchTaken, MEM_MemAccess, Mem_Ready,
        input  PCWre, IF_ID_Write, Stage_Hold, IF_ID_Flush, ID_EX_Flush,
               EX_MEM_Flush, Trap, State
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_WriteReg,
               MEM_BranchTaken, MEM_MemAccess, Mem_Ready,
        output PCWre, IF_ID_Write, Stage_Hold, IF_ID_Flush, ID_EX_Flush,
               EX_MEM_Flush, Trap, State
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble, branch flush, memory-wait freeze with timeout trap.
// Optional HAZARD_PERF_CNT_EN adds saturating Stall_Cnt/Flush_Cnt/Wait_Cnt outputs.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                      Clk,
    input  logic                      Reset,
    pipeline_hazard_ctrl_if.slave     bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          Stall_Cnt,
    output logic [CNT_W-1:0]          Flush_Cnt,
    output logic [CNT_W-1:0]          Wait_Cnt
`endif
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       w_load_use;
    logic       w_hold_req;

    assign w_load_use = bus.EX_MemRead && (bus.EX_WriteReg != 5'd0) &&
                        ((bus.EX_WriteReg == bus.ID_Rs) ||
                         (bus.ID_UsesRt && (bus.EX_WriteReg == bus.ID_Rt)));

    // Once waiting, only Mem_Ready releases the freeze regardless of MEM_MemAccess.
    assign w_hold_req = (r_state == ST_MEM_WAIT) ? !bus.Mem_Ready
                                                 : (bus.MEM_MemAccess && !bus.Mem_Ready);

    always_comb begin
        bus.PCWre        = 1'b1;
        bus.IF_ID_Write  = 1'b1;
        bus.Stage_Hold   = 1'b0;
        bus.IF_ID_Flush  = 1'b0;
        bus.ID_EX_Flush  = 1'b0;
        bus.EX_MEM_Flush = 1'b0;
        bus.Trap         = 1'b0;
        if (!Reset) begin
            if (r_state == ST_TRAP) begin
                bus.PCWre       = 1'b0;
                bus.IF_ID_Write = 1'b0;
                bus.Stage_Hold  = 1'b1;
                bus.Trap        = 1'b1;
            end else if (w_hold_req) begin
                bus.PCWre       = 1'b0;
                bus.IF_ID_Write = 1'b0;
                bus.Stage_Hold  = 1'b1;
            end else if (bus.MEM_BranchTaken) begin
                bus.IF_ID_Flush  = 1'b1;
                bus.ID_EX_Flush  = 1'b1;
                bus.EX_MEM_Flush = 1'b1;
            end else if (w_load_use) begin
                bus.PCWre       = 1'b0;
                bus.IF_ID_Write = 1'b0;
                bus.ID_EX_Flush = 1'b1;
            end
        end
    end

    assign bus.State = r_state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hold_req) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.Mem_Ready) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == 8'(MEM_TIMEOUT)) begin
                        r_state <= ST_TRAP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_TRAP;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_wait_evt_cnt;
    logic [2:0]       w_evt;

    // Wait_Cnt counts only frozen MEM_WAIT cycles; the releasing ready cycle is not a wait.
    assign w_evt = {(r_state == ST_MEM_WAIT) && !bus.Mem_Ready,
                    bus.EX_MEM_Flush,
                    !bus.PCWre};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cnt    <= '0;
            r_flush_cnt    <= '0;
            r_wait_evt_cnt <= '0;
        end else begin
            if (w_evt[0] && !(&r_stall_cnt))    r_stall_cnt    <= r_stall_cnt + 1'b1;
            if (w_evt[1] && !(&r_flush_cnt))    r_flush_cnt    <= r_flush_cnt + 1'b1;
            if (w_evt[2] && !(&r_wait_evt_cnt)) r_wait_evt_cnt <= r_wait_evt_cnt + 1'b1;
        end
    end

    assign Stall_Cnt = r_stall_cnt;
    assign Flush_Cnt = r_flush_cnt;
    assign Wait_Cnt  = r_wait_evt_cnt;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, $0, branch priority, memory wait, timeout trap, reset.
// With HAZARD_PERF_CNT_EN defined it also checks the performance counters.
module tb_pipeline_hazard_ctrl;
    logic Clk = 1'b0;
    logic Reset;
    int   n_total = 0;
    int   n_pass  = 0;

    pipeline_hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt, wait_cnt;
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .bus(hif.slave),
        .Stall_Cnt(stall_cnt), .Flush_Cnt(flush_cnt), .Wait_Cnt(wait_cnt)
    );
`else
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .bus(hif.slave)
    );
`endif

    always #5 Clk = ~Clk;

    // Packed view: {PCWre, IF_ID_Write, Stage_Hold, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Trap, State[1:0]}
    localparam logic [8:0] RUN0  = 9'b110_000_0_00;
    localparam logic [8:0] LU0   = 9'b000_010_0_00;
    localparam logic [8:0] BR0   = 9'b110_111_0_00;
    localparam logic [8:0] HOLD0 = 9'b001_000_0_00;
    localparam logic [8:0] HOLD1 = 9'b001_000_0_01;
    localparam logic [8:0] BR1   = 9'b110_111_0_01;
    localparam logic [8:0] TRAP2 = 9'b001_000_1_10;
    localparam logic [8:0] RST2  = 9'b110_000_0_10;

    function automatic logic [8:0] obs();
        return {hif.PCWre, hif.IF_ID_Write, hif.Stage_Hold, hif.IF_ID_Flush,
                hif.ID_EX_Flush, hif.EX_MEM_Flush, hif.Trap, hif.State};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    // One cycle: drive at negedge, check the Mealy outputs and current State 1 time unit later.
    task automatic step(input string tag, input logic rst,
                        input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic mem_rd, input logic [4:0] wr, input logic br,
                        input logic acc, input logic rdy, input logic [8:0] exp_v);
        @(negedge Clk);
        Reset               = rst;
        hif.ID_Rs           = rs;
        hif.ID_Rt           = rt;
        hif.ID_UsesRt       = uses_rt;
        hif.EX_MemRead      = mem_rd;
        hif.EX_WriteReg     = wr;
        hif.MEM_BranchTaken = br;
        hif.MEM_MemAccess   = acc;
        hif.Mem_Ready       = rdy;
        #1;
        check(tag, 32'(obs()), 32'(exp_v));
        $display("step %-14s rst=%0b rs=%0d rt=%0d ur=%0b mr=%0b wr=%0d br=%0b acc=%0b rdy=%0b out=%09b",
                 tag, rst, rs, rt, uses_rt, mem_rd, wr, br, acc, rdy, obs());
    endtask

    initial begin
        Reset = 1'b1;
        hif.ID_Rs = '0; hif.ID_Rt = '0; hif.ID_UsesRt = 1'b0; hif.EX_MemRead = 1'b0;
        hif.EX_WriteReg = '0; hif.MEM_BranchTaken = 1'b0; hif.MEM_MemAccess = 1'b0;
        hif.Mem_Ready = 1'b0;

        // Reset forces RUN defaults even with a load-use present.
        step("reset0",     1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, RUN0);
        step("reset1",     1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, RUN0);
        step("idle",       0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RUN0);
        step("loaduse_rs", 0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, LU0);
        step("after_lu",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RUN0);
        step("reg0",       0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, RUN0);
        step("rt_unused",  0, 5'd1, 5'd7, 0, 1, 5'd7, 0, 0, 0, RUN0);
        step("loaduse_rt", 0, 5'd1, 5'd7, 1, 1, 5'd7, 0, 0, 0, LU0);
        step("no_load",    0, 5'd7, 5'd7, 1, 0, 5'd7, 0, 0, 0, RUN0);
        step("branch_lu",  0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0, BR0);
        step("branch",     0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, BR0);
        // Memory wait with a load-use present: hold wins, then branch acts in the ready cycle.
        step("wait1_lu",   0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 1, 0, HOLD0);
        step("wait2",      0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 1, 0, HOLD1);
        step("wait3_noacc",0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, HOLD1);
        step("ready_br",   0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1, BR1);
        step("post_wait",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RUN0);
        step("lu_retry",   0, 5'd3, 5'd0, 0, 1, 5'd3, 0, 1, 1, LU0);
        // Timeout: 1 RUN hold cycle + 15 MEM_WAIT cycles, then TRAP.
        step("to_hold0",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, HOLD0);
        for (int i = 1; i < 16; i++)
            step($sformatf("to_hold%0d", i), 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, HOLD1);
        step("trap",       0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, TRAP2);
        step("trap_sticky",0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 1, TRAP2);
        step("trap_rst",   1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RST2);
        step("trap_exit",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RUN0);

`ifdef HAZARD_PERF_CNT_EN
        step("pc_reset",   1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RUN0);
        step("pc_idle",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RUN0);
        check("cnt_clr_stall", 32'(stall_cnt), 32'd0);
        check("cnt_clr_flush", 32'(flush_cnt), 32'd0);
        check("cnt_clr_wait",  32'(wait_cnt),  32'd0);
        step("pc_lu",      0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, LU0);
        step("pc_br",      0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0, BR0);
        step("pc_w1",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, HOLD0);
        step("pc_w2",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, HOLD1);
        step("pc_w3",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, HOLD1);
        step("pc_rdy",     0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 9'b110_000_0_01);
        step("pc_end",     0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RUN0);
        check("cnt_stall", 32'(stall_cnt), 32'd4);
        check("cnt_flush", 32'(flush_cnt), 32'd1);
        check("cnt_wait",  32'(wait_cnt),  32'd2);
        step("pc_reset2",  1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RUN0);
        step("pc_idle2",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, RUN0);
        check("cnt_rst_stall", 32'(stall_cnt), 32'd0);
        check("cnt_rst_flush", 32'(flush_cnt), 32'd0);
        check("cnt_rst_wait",  32'(wait_cnt),  32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
